// File: rtl/instr_fetch_unit.sv
// RV32 instruction fetch front end: owns the PC, keeps one memory request in flight,
// and presents the returned word to decode through a single-entry output register.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    input  logic            if_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    output logic [31:0]     if_instr,
    output logic [6:0]      if_opcode
);
    localparam logic [0:0] S_REQ  = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]      state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic            drop_reg, drop_next;
    logic            if_valid_reg, if_valid_next;
    logic [XLEN-1:0] if_pc_reg, if_pc_next;
    logic [31:0]     if_instr_reg, if_instr_next;
    logic            req_fire;

    // A request only goes out when the buffer is empty or draining, so the
    // response always has somewhere to land.
    assign imem_req_valid = !rst && (state_reg == S_REQ) && !halt
                            && (!if_valid_reg || if_ready);
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign imem_addr      = pc_reg;

    assign if_valid    = if_valid_reg;
    assign if_pc       = if_pc_reg;
    assign if_pc_plus4 = if_pc_reg + XLEN'(4);
    assign if_instr    = if_instr_reg;
    assign if_opcode   = if_instr_reg[6:0];

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        drop_next     = drop_reg;
        if_valid_next = if_valid_reg;
        if_pc_next    = if_pc_reg;
        if_instr_next = if_instr_reg;

        if (redirect_valid) begin
            // Redirect wins over everything: flush the buffer and mark any
            // fetch still in flight as stale.
            pc_next       = redirect_pc & ~XLEN'(3);
            if_valid_next = 1'b0;
            if (state_reg == S_WAIT) begin
                if (imem_resp_valid) begin
                    state_next = S_REQ;
                    drop_next  = 1'b0;
                end else begin
                    drop_next  = 1'b1;
                end
            end else if (req_fire) begin
                state_next = S_WAIT;
                drop_next  = 1'b1;
            end
        end else begin
            if (if_valid_reg && if_ready) begin
                if_valid_next = 1'b0;
            end
            case (state_reg)
                S_REQ: begin
                    if (req_fire) begin
                        state_next = S_WAIT;
                    end
                end
                default: begin
                    if (imem_resp_valid) begin
                        state_next = S_REQ;
                        drop_next  = 1'b0;
                        if (!drop_reg) begin
                            if_instr_next = imem_resp_data;
                            if_pc_next    = pc_reg;
                            if_valid_next = 1'b1;
                            pc_next       = pc_reg + XLEN'(4);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_REQ;
            pc_reg       <= RESET_PC;
            drop_reg     <= 1'b0;
            if_valid_reg <= 1'b0;
            if_pc_reg    <= '0;
            if_instr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            drop_reg     <= drop_next;
            if_valid_reg <= if_valid_next;
            if_pc_reg    <= if_pc_next;
            if_instr_reg <= if_instr_next;
        end
    end
endmodule
